slice_hit_detector: RTL and testbench



---
 rtl/slice_hit_detector.sv | 211 +++++++++++++++++++++
 tb/tb_slice_hit_detector.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_hit_detector.sv
// slice_hit_detector
// Once per video frame, snapshots the cursor, streak flag and all sprite slots, then walks the
// slots one per cycle. A slot is "sliced" when the blade is down, the slot is in the sliceable
// state, the cursor lies inside its hitbox and it has not already been sliced this streak.
// Each slice sets a sticky mask bit, bumps a saturating counter and queues the slot index in a
// first-word-fall-through event FIFO that software drains with a valid/ack handshake.

module slice_hit_detector #(
    parameter int unsigned NUM_SPRITES  = 15,
    parameter int unsigned HIT_W        = 32,
    parameter int unsigned HIT_H        = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [2:0]  ACTIVE_STATE = 3'd1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic [9:0]                 cursor_x,
    input  logic [9:0]                 cursor_y,
    input  logic                       streak,
    input  logic [10*NUM_SPRITES-1:0]  sprite_x,
    input  logic [10*NUM_SPRITES-1:0]  sprite_y,
    input  logic [3*NUM_SPRITES-1:0]   sprite_state,
    output logic [NUM_SPRITES-1:0]     hit_mask,
    output logic                       evt_valid,
    output logic [3:0]                 evt_slot,
    input  logic                       evt_ack,
    output logic [15:0]                hit_count,
    output logic                       overflow,
    output logic                       busy
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [3:0]      LastIdx = 4'(NUM_SPRITES - 1);
    localparam logic [10:0]     HitW11  = 11'(HIT_W);
    localparam logic [10:0]     HitH11  = 11'(HIT_H);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLatch,
        StScan,
        StDone
    } state_e;

    state_e state_q;
    logic [3:0] idx_q;

    // Frame snapshot: everything the scan looks at is frozen in LATCH
    logic [9:0]                 snap_cx_q;
    logic [9:0]                 snap_cy_q;
    logic                       snap_streak_q;
    logic [10*NUM_SPRITES-1:0]  snap_x_q;
    logic [10*NUM_SPRITES-1:0]  snap_y_q;
    logic [3*NUM_SPRITES-1:0]   snap_st_q;

    // Event FIFO
    logic [3:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] fifo_cnt_q;

    // Per-slot views of the snapshot buses
    logic [9:0] sx_arr [NUM_SPRITES];
    logic [9:0] sy_arr [NUM_SPRITES];
    logic [2:0] st_arr [NUM_SPRITES];

    logic [9:0] cur_sx;
    logic [9:0] cur_sy;
    logic [2:0] cur_st;
    logic       slot_active;
    logic       in_box;
    logic       scan_hit;

    logic fifo_empty;
    logic fifo_full;
    logic fifo_pop;
    logic fifo_push;

    // Unpack the snapshot buses into per-slot arrays
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            sx_arr[i] = snap_x_q[10*i +: 10];
            sy_arr[i] = snap_y_q[10*i +: 10];
            st_arr[i] = snap_st_q[3*i +: 3];
        end
    end

    // Hit test for the slot currently addressed by the scan index
    always_comb begin
        cur_sx      = sx_arr[idx_q];
        cur_sy      = sy_arr[idx_q];
        cur_st      = st_arr[idx_q];
        slot_active = (cur_st == ACTIVE_STATE);
        // Upper bounds are formed at 11 bits so sprites near x/y = 1023 do not wrap
        in_box      = (cur_sx <= snap_cx_q)
                   && ({1'b0, snap_cx_q} < ({1'b0, cur_sx} + HitW11))
                   && (cur_sy <= snap_cy_q)
                   && ({1'b0, snap_cy_q} < ({1'b0, cur_sy} + HitH11));
        scan_hit    = (state_q == StScan) && snap_streak_q && slot_active && in_box
                   && !hit_mask[idx_q];
    end

    // FIFO handshake decode; a push into a full FIFO is accepted only if a pop frees a slot
    always_comb begin
        fifo_empty = (fifo_cnt_q == '0);
        fifo_full  = (fifo_cnt_q == FullCnt);
        fifo_pop   = evt_ack && !fifo_empty;
        fifo_push  = scan_hit && (!fifo_full || fifo_pop);
        evt_valid  = !fifo_empty;
        evt_slot   = fifo_empty ? 4'd0 : fifo_mem_q[rd_ptr_q];
    end

    // Scan sequencer with snapshot, slice mask and slice counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            idx_q         <= 4'd0;
            busy          <= 1'b0;
            hit_mask      <= '0;
            hit_count     <= 16'd0;
            snap_cx_q     <= 10'd0;
            snap_cy_q     <= 10'd0;
            snap_streak_q <= 1'b0;
            snap_x_q      <= '0;
            snap_y_q      <= '0;
            snap_st_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (frame_tick) begin
                        state_q <= StLatch;
                    end
                end
                StLatch: begin
                    snap_cx_q     <= cursor_x;
                    snap_cy_q     <= cursor_y;
                    snap_streak_q <= streak;
                    snap_x_q      <= sprite_x;
                    snap_y_q      <= sprite_y;
                    snap_st_q     <= sprite_state;
                    idx_q         <= 4'd0;
                    busy          <= 1'b1;
                    // Lifting the blade ends the streak, so every slot becomes sliceable again
                    if (!streak) begin
                        hit_mask <= '0;
                    end
                    state_q <= StScan;
                end
                StScan: begin
                    // A slot that left the active state has despawned; re-arm it for its respawn
                    if (!slot_active) begin
                        hit_mask[idx_q] <= 1'b0;
                    end else if (scan_hit) begin
                        hit_mask[idx_q] <= 1'b1;
                        if (hit_count != 16'hFFFF) begin
                            hit_count <= hit_count + 16'd1;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= idx_q;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            overflow   <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (fifo_push && !fifo_pop) begin
                fifo_cnt_q <= fifo_cnt_q + CntW'(1);
            end else if (!fifo_push && fifo_pop) begin
                fifo_cnt_q <= fifo_cnt_q - CntW'(1);
            end
            if (scan_hit && !fifo_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slice_hit_detector.sv
// Bench for slice_hit_detector: directed scenarios plus randomized frames, checked against a
// frame-level reference model. Expected events go into a queue; a monitor pops and compares
// on every DUT handshake.

module tb_slice_hit_detector;

    localparam int N     = 15;
    localparam int DEPTH = 8;
    localparam int HW    = 32;
    localparam int HH    = 32;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic              reset;
    logic              frame_tick;
    logic              evt_ack;
    logic [9:0]        cursor_x;
    logic [9:0]        cursor_y;
    logic              streak;
    logic [10*N-1:0]   sprite_x;
    logic [10*N-1:0]   sprite_y;
    logic [3*N-1:0]    sprite_state;
    logic [N-1:0]      hit_mask;
    logic              evt_valid;
    logic [3:0]        evt_slot;
    logic [15:0]       hit_count;
    logic              overflow;
    logic              busy;

    // Stimulus variables
    int cx;
    int cy;
    bit stk;
    int in_x [N];
    int in_y [N];
    int in_st [N];

    // Reference model state
    int       exp_q [$];
    bit [N-1:0] m_mask;
    int       m_count;
    bit       m_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cycles = 0;
    int n;

    slice_hit_detector #(
        .NUM_SPRITES (N),
        .HIT_W       (HW),
        .HIT_H       (HH),
        .FIFO_DEPTH  (DEPTH),
        .ACTIVE_STATE(3'd1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .streak      (streak),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .sprite_state(sprite_state),
        .hit_mask    (hit_mask),
        .evt_valid   (evt_valid),
        .evt_slot    (evt_slot),
        .evt_ack     (evt_ack),
        .hit_count   (hit_count),
        .overflow    (overflow),
        .busy        (busy)
    );

    always_comb begin
        cursor_x = cx[9:0];
        cursor_y = cy[9:0];
        streak   = stk;
        for (int i = 0; i < N; i++) begin
            sprite_x[10*i +: 10]    = in_x[i][9:0];
            sprite_y[10*i +: 10]    = in_y[i][9:0];
            sprite_state[3*i +: 3]  = in_st[i][2:0];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-frame model: slots are visited in index order and the queue holds at most cap entries
    function automatic void model_frame(input int cap);
        if (!stk) m_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (in_st[i] != 1) begin
                m_mask[i] = 1'b0;
            end else if (stk && !m_mask[i] && cx >= in_x[i] && cx < in_x[i] + HW
                         && cy >= in_y[i] && cy < in_y[i] + HH) begin
                m_mask[i] = 1'b1;
                if (m_count < 65535) m_count++;
                if (exp_q.size() < cap) exp_q.push_back(i);
                else m_ovf = 1'b1;
            end
        end
    endfunction

    // Busy-length measurement
    always @(negedge clk) begin
        if (busy) busy_cycles++;
    end

    // Monitor: every accepted pop must present the oldest expected slot
    always @(negedge clk) begin
        if (!reset && evt_ack && evt_valid) begin
            if (exp_q.size() == 0) begin
                check("evt_pop_unexpected", int'(evt_slot), -1);
            end else begin
                check("evt_slot_pop", int'(evt_slot), exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic post_check(input string tag);
        check({tag, "_mask"}, int'(hit_mask), int'(m_mask));
        check({tag, "_count"}, int'(hit_count), m_count);
        check({tag, "_ovf"}, int'(overflow), int'(m_ovf));
        check({tag, "_valid"}, int'(evt_valid), int'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, "_head"}, int'(evt_slot), exp_q[0]);
    endtask

    // One frame: optional ack pulse exactly in the first scan cycle, optional tick while busy
    task automatic do_frame(input string tag, input bit ack_push, input bit retick);
        busy_cycles = 0;
        @(posedge clk); #1;
        frame_tick = 1'b1;
        // With an ack landing on the push cycle the queue may briefly hold one extra entry
        model_frame(ack_push ? DEPTH + 1 : DEPTH);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        if (ack_push) evt_ack = 1'b1;
        @(posedge clk); #1;
        evt_ack = 1'b0;
        if (retick) frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        check({tag, "_busy_len"}, busy_cycles, N + 1);
        if (retick) begin
            repeat (20) @(negedge clk);
            check({tag, "_no_second_scan"}, busy_cycles, N + 1);
        end
        post_check(tag);
    endtask

    task automatic drain(input int max_n, output int cnt);
        cnt = 0;
        for (int k = 0; k < max_n; k++) begin
            @(posedge clk); #1;
            if (!evt_valid) break;
            evt_ack = 1'b1;
            cnt++;
            @(posedge clk); #1;
            evt_ack = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset      = 1'b1;
        evt_ack    = 1'b0;
        frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_mask  = '0;
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < N; i++) begin
            in_x[i]  = 0;
            in_y[i]  = 0;
            in_st[i] = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        frame_tick = 1'b0;
        evt_ack = 1'b0;
        cx = 0;
        cy = 0;
        stk = 1'b0;
        clear_slots();
        m_mask = '0;
        m_count = 0;
        m_ovf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mask", int'(hit_mask), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_slot", int'(evt_slot), 0);
        check("rst_count", int'(hit_count), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic slice of slot 2
        in_x[2] = 100; in_y[2] = 200; in_st[2] = 1;
        cx = 110; cy = 215; stk = 1'b1;
        do_frame("t1", 1'b0, 1'b0);
        check("t1_mask_const", int'(hit_mask), 4);
        check("t1_slot_const", int'(evt_slot), 2);
        drain(20, n);
        check("t1_drain", n, 1);
        check("t1_empty", int'(evt_valid), 0);

        // No re-slice within a streak, re-slice after the blade is lifted
        repeat (3) do_frame("t2_hold", 1'b0, 1'b0);
        check("t2_count_hold", int'(hit_count), 1);
        stk = 1'b0;
        do_frame("t2_lift", 1'b0, 1'b0);
        stk = 1'b1;
        do_frame("t2_again", 1'b0, 1'b0);
        check("t2_count_again", int'(hit_count), 2);
        drain(20, n);

        // Hitbox edges near the top of the coordinate range
        in_st[2] = 0;
        in_x[0] = 1000; in_y[0] = 0; in_st[0] = 1;
        cx = 1019; cy = 31;
        do_frame("t3_corner", 1'b0, 1'b0);
        stk = 1'b0;
        do_frame("t3_lift", 1'b0, 1'b0);
        stk = 1'b1;
        cx = 999; cy = 5;
        do_frame("t3_left", 1'b0, 1'b0);
        cx = 1000; cy = 32;
        do_frame("t3_below", 1'b0, 1'b0);
        cx = 1023; cy = 0;
        do_frame("t3_nowrap", 1'b0, 1'b0);
        in_st[0] = 2;
        do_frame("t3_despawn", 1'b0, 1'b0);
        check("t3_mask_clear", int'(hit_mask), 0);
        drain(20, n);

        // Overflow: ten hits, eight queued
        do_reset();
        clear_slots();
        for (int i = 0; i < 10; i++) begin
            in_x[i] = 300; in_y[i] = 300; in_st[i] = 1;
        end
        cx = 310; cy = 310; stk = 1'b1;
        do_frame("t4", 1'b0, 1'b0);
        check("t4_ovf_const", int'(overflow), 1);
        check("t4_count_const", int'(hit_count), 10);
        drain(20, n);
        check("t4_drain", n, DEPTH);

        // Full FIFO with a pop in the push cycle
        do_reset();
        clear_slots();
        for (int i = 0; i < DEPTH; i++) begin
            in_x[i] = 500; in_y[i] = 40; in_st[i] = 1;
        end
        cx = 520; cy = 60; stk = 1'b1;
        do_frame("t5_fill", 1'b0, 1'b0);
        stk = 1'b0;
        do_frame("t5_lift", 1'b0, 1'b0);
        stk = 1'b1;
        for (int i = 1; i < DEPTH; i++) in_st[i] = 0;
        do_frame("t5_pushpop", 1'b1, 1'b0);
        check("t5_ovf_const", int'(overflow), 0);
        drain(20, n);
        check("t5_drain", n, DEPTH);

        // Reset during the scan, then a tick while busy
        do_reset();
        clear_slots();
        for (int i = 0; i < 10; i++) begin
            in_x[i] = 20; in_y[i] = 20; in_st[i] = 1;
        end
        cx = 25; cy = 25; stk = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t6_busy_before", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_mask", int'(hit_mask), 0);
        check("t6_valid", int'(evt_valid), 0);
        check("t6_slot", int'(evt_slot), 0);
        check("t6_count", int'(hit_count), 0);
        check("t6_ovf", int'(overflow), 0);
        check("t6_busy", int'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        m_mask = '0; m_count = 0; m_ovf = 1'b0;
        busy_cycles = 0;
        repeat (5) @(negedge clk);
        check("t6_idle", busy_cycles, 0);
        do_frame("t6_retick", 1'b0, 1'b1);
        drain(20, n);

        // Randomized frames
        do_reset();
        for (int f = 0; f < 40; f++) begin
            stk = ($urandom_range(0, 4) != 0);
            cx = int'($urandom_range(0, 1023));
            cy = int'($urandom_range(0, 1023));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    in_x[i] = cx - int'($urandom_range(0, 40));
                    in_y[i] = cy - int'($urandom_range(0, 40));
                    if (in_x[i] < 0) in_x[i] = 0;
                    if (in_y[i] < 0) in_y[i] = 0;
                end else begin
                    in_x[i] = int'($urandom_range(0, 1023));
                    in_y[i] = int'($urandom_range(0, 1023));
                end
                in_st[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 1;
            end
            do_frame("rnd", 1'b0, 1'b0);
            drain(int'($urandom_range(0, 6)), n);
        end
        drain(20, n);
        check("rnd_final_empty", int'(evt_valid), 0);
        check("rnd_model_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
